// File: rtl/div_job_sequencer_pkg.sv
// Shared types and constants for the divider job sequencer: FSM state encoding,
// result status codes and the completion-priority helper.
package div_job_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ABORT = 3'd3,
        S_HOLD  = 3'd4
    } seq_state_e;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK  = 2'd0;
    localparam status_t ST_OVF = 2'd1;
    localparam status_t ST_DVZ = 2'd2;
    localparam status_t ST_TMO = 2'd3;

    // Divide-by-zero outranks overflow, which outranks a normal finish.
    function automatic status_t completion_status(input logic dvz, input logic ovf);
        if (dvz) begin
            return ST_DVZ;
        end else if (ovf) begin
            return ST_OVF;
        end
        return ST_OK;
    endfunction

endpackage

// File: rtl/div_job_sequencer_if.sv
// Bundle of the job input, divider-side and result-output signals of the sequencer.
// master = sequencer side, slave = environment (producer, divider, consumer).
interface div_job_sequencer_if
    import div_job_sequencer_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             div_start;
    logic             div_abort;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_busy;
    logic             div_valid;
    logic             div_ovf;
    logic             div_dvz;
    logic [WIDTH-1:0] div_q;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    status_t          out_status;
    logic [CNT_W-1:0] jobs_done;

    modport master (
        input  in_valid, in_a, in_b,
        input  div_busy, div_valid, div_ovf, div_dvz, div_q,
        input  out_ready,
        output in_ready,
        output div_start, div_abort, div_a, div_b,
        output out_valid, out_q, out_status, jobs_done
    );

    modport slave (
        output in_valid, in_a, in_b,
        output div_busy, div_valid, div_ovf, div_dvz, div_q,
        output out_ready,
        input  in_ready,
        input  div_start, div_abort, div_a, div_b,
        input  out_valid, out_q, out_status, jobs_done
    );

endinterface

// File: rtl/div_watchdog.sv
// Loadable up-counter with clear, enable and a terminal flag at TIMEOUT_CYC-1.
// Stops at the terminal value rather than wrapping.
module div_watchdog #(
    parameter  int TIMEOUT_CYC = 64,
    localparam int CW          = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic          clk,
    input  logic          sclr,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          term_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign term_o = (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_job_sequencer.sv
// Issue stage for the sequential divider: accepts a job, pulses start, waits for
// a completion pulse (or watchdog / lost-start abort) and hands the result downstream.
module div_job_sequencer
    import div_job_sequencer_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               sclr,
    div_job_sequencer_if.master io
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic             div_start_q, div_start_d;
    logic             div_abort_q, div_abort_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q_q, out_q_d;
    status_t          out_status_q, out_status_d;
    logic [CNT_W-1:0] jobs_done_q, jobs_done_d;
    logic             busy_low_q, busy_low_d;

    logic             wd_clear;
    logic             wd_en;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_term;
    logic             first_wait;

    div_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .sclr      (sclr),
        .clear_i   (wd_clear),
        .load_i    (1'b0),
        .load_val_i('0),
        .en_i      (wd_en),
        .cnt_o     (wd_cnt),
        .term_o    (wd_term)
    );

    // The counter is cleared in ISSUE, so zero marks the first WAIT cycle,
    // during which the divider may not yet report busy.
    assign first_wait = (wd_cnt == '0);

    always_comb begin
        state_d      = state_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        out_q_d      = out_q_q;
        out_status_d = out_status_q;
        jobs_done_d  = jobs_done_q;
        busy_low_d   = busy_low_q;
        wd_clear     = 1'b0;
        wd_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    div_a_d = io.in_a;
                    div_b_d = io.in_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_clear   = 1'b1;
                busy_low_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                if (io.div_dvz || io.div_ovf || io.div_valid) begin
                    out_status_d = completion_status(io.div_dvz, io.div_ovf);
                    out_q_d      = io.div_dvz ? '0 : io.div_q;
                    state_d      = S_HOLD;
                end else if (wd_term) begin
                    state_d = S_ABORT;
                end else if (!first_wait && !io.div_busy) begin
                    if (busy_low_q) begin
                        state_d = S_ABORT;
                    end else begin
                        busy_low_d = 1'b1;
                    end
                end else begin
                    busy_low_d = 1'b0;
                end
            end
            S_ABORT: begin
                out_status_d = ST_TMO;
                out_q_d      = '0;
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                if (io.out_ready) begin
                    jobs_done_d = jobs_done_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered strobes are derived from the next state so they coincide with it.
    assign div_start_d = (state_d == S_ISSUE);
    assign div_abort_d = (state_d == S_ABORT);
    assign out_valid_d = (state_d == S_HOLD);

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q      <= S_IDLE;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_start_q  <= 1'b0;
            div_abort_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q_q      <= '0;
            out_status_q <= ST_OK;
            jobs_done_q  <= '0;
            busy_low_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_start_q  <= div_start_d;
            div_abort_q  <= div_abort_d;
            out_valid_q  <= out_valid_d;
            out_q_q      <= out_q_d;
            out_status_q <= out_status_d;
            jobs_done_q  <= jobs_done_d;
            busy_low_q   <= busy_low_d;
        end
    end

    assign io.in_ready   = (state_q == S_IDLE);
    assign io.div_start  = div_start_q;
    assign io.div_abort  = div_abort_q;
    assign io.div_a      = div_a_q;
    assign io.div_b      = div_b_q;
    assign io.out_valid  = out_valid_q;
    assign io.out_q      = out_q_q;
    assign io.out_status = out_status_q;
    assign io.jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Directed bench for div_job_sequencer with a small behavioural divider model.
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_div_job_sequencer;

    localparam int WIDTH       = 10;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 64;

    localparam int M_VALID   = 0;
    localparam int M_DVZ     = 1;
    localparam int M_OVF_VAL = 2;
    localparam int M_ALL     = 3;
    localparam int M_HANG    = 4;
    localparam int M_SILENT  = 5;

    logic clk = 1'b0;
    logic sclr;

    always #5 clk = ~clk;

    div_job_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dif ();

    div_job_sequencer #(
        .WIDTH(WIDTH),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .sclr(sclr),
        .io  (dif.master)
    );

    int checks = 0;
    int errors = 0;

    int         m_mode   = M_VALID;
    int         m_lat    = 6;
    logic [9:0] m_q      = 10'h000;
    bit         m_en     = 1'b1;
    bit         m_active = 1'b0;
    int         m_rem    = 0;

    // Divider model: reacts to div_start, holds busy, then fires the mode's pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_en) begin
                dif.div_valid = 1'b0;
                dif.div_ovf   = 1'b0;
                dif.div_dvz   = 1'b0;
                if (sclr) begin
                    m_active     = 1'b0;
                    dif.div_busy = 1'b0;
                end else if (m_active) begin
                    if (dif.div_abort) begin
                        m_active     = 1'b0;
                        dif.div_busy = 1'b0;
                    end else if (m_mode == M_HANG) begin
                        dif.div_busy = 1'b1;
                    end else if (m_mode == M_SILENT) begin
                        dif.div_busy = 1'b0;
                    end else begin
                        m_rem        = m_rem - 1;
                        dif.div_busy = 1'b1;
                        if (m_rem == 0) begin
                            dif.div_q     = m_q;
                            dif.div_valid = (m_mode == M_VALID) || (m_mode == M_OVF_VAL) || (m_mode == M_ALL);
                            dif.div_ovf   = (m_mode == M_OVF_VAL) || (m_mode == M_ALL);
                            dif.div_dvz   = (m_mode == M_DVZ) || (m_mode == M_ALL);
                            m_active      = 1'b0;
                        end
                    end
                end else begin
                    dif.div_busy = 1'b0;
                    if (dif.div_start) begin
                        m_active = 1'b1;
                        m_rem    = m_lat;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer_job(input logic [9:0] a, input logic [9:0] b);
        dif.in_valid = 1'b1;
        dif.in_a     = a;
        dif.in_b     = b;
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!dif.out_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        tick();
        tick();
        sclr = 1'b0;
        checks++;
        if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", dif.in_ready); end
        checks++;
        if (dif.div_start !== 1'b0 || dif.div_abort !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got start=%b abort=%b want 0 0", dif.div_start, dif.div_abort);
        end
        checks++;
        if (dif.div_a !== 10'h0 || dif.div_b !== 10'h0) begin
            errors++; $display("FAIL reset_div_ab got %h %h want 000 000", dif.div_a, dif.div_b);
        end
        checks++;
        if (dif.out_valid !== 1'b0 || dif.out_q !== 10'h0 || dif.out_status !== 2'd0) begin
            errors++; $display("FAIL reset_out got v=%b q=%h st=%0d want 0 000 0", dif.out_valid, dif.out_q, dif.out_status);
        end
        checks++;
        if (dif.jobs_done !== 16'd0) begin errors++; $display("FAIL reset_jobs got %0d want 0", dif.jobs_done); end
        $display("reset: in_ready=%b out_valid=%b jobs_done=%0d", dif.in_ready, dif.out_valid, dif.jobs_done);
    endtask

    task automatic test_normal();
        int n;
        int extra_starts;
        m_mode = M_VALID; m_lat = 6; m_q = 10'h0A5;
        offer_job(10'd200, 10'd3);
        checks++;
        if (dif.div_start !== 1'b1 || dif.in_ready !== 1'b0) begin
            errors++; $display("FAIL normal_issue got start=%b in_ready=%b want 1 0", dif.div_start, dif.in_ready);
        end
        checks++;
        if (dif.div_a !== 10'd200 || dif.div_b !== 10'd3) begin
            errors++; $display("FAIL normal_operands got %0d %0d want 200 3", dif.div_a, dif.div_b);
        end
        n = 0; extra_starts = 0;
        while (!dif.out_valid && n < 200) begin
            tick();
            n++;
            if (dif.div_start) extra_starts++;
        end
        checks++;
        if (n != 7) begin errors++; $display("FAIL normal_latency got %0d want 7", n); end
        checks++;
        if (extra_starts != 0) begin errors++; $display("FAIL normal_single_start got %0d extra want 0", extra_starts); end
        checks++;
        if (dif.out_q !== 10'h0A5 || dif.out_status !== 2'd0) begin
            errors++; $display("FAIL normal_result got q=%h st=%0d want 0a5 0", dif.out_q, dif.out_status);
        end
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        checks++;
        if (dif.out_valid !== 1'b0 || dif.jobs_done !== 16'd1 || dif.in_ready !== 1'b1) begin
            errors++; $display("FAIL normal_handoff got v=%b jobs=%0d rdy=%b want 0 1 1", dif.out_valid, dif.jobs_done, dif.in_ready);
        end
        $display("normal: latency=%0d q=%h status=%0d jobs_done=%0d", n, dif.out_q, dif.out_status, dif.jobs_done);
    endtask

    task automatic test_dvz();
        int n;
        m_mode = M_DVZ; m_lat = 4; m_q = 10'h3FF;
        offer_job(10'd123, 10'd0);
        wait_out(n);
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_status !== 2'd2 || dif.out_q !== 10'h0) begin
            errors++; $display("FAIL dvz_result got v=%b st=%0d q=%h want 1 2 000", dif.out_valid, dif.out_status, dif.out_q);
        end
        dif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dif.in_ready !== 1'b0) begin errors++; $display("FAIL dvz_in_ready_held cycle %0d got %b want 0", i, dif.in_ready); end
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        checks++;
        if (dif.in_ready !== 1'b1 || dif.jobs_done !== 16'd2) begin
            errors++; $display("FAIL dvz_handoff got rdy=%b jobs=%0d want 1 2", dif.in_ready, dif.jobs_done);
        end
        $display("dvz: status=2 expected, jobs_done=%0d", dif.jobs_done);
    endtask

    task automatic test_priority(input int mode, input logic [9:0] q, input logic [1:0] exp_st,
                                 input logic [9:0] exp_q, input logic [15:0] exp_jobs);
        int n;
        m_mode = mode; m_lat = 5; m_q = q;
        offer_job(10'd500, 10'd7);
        wait_out(n);
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_status !== exp_st || dif.out_q !== exp_q) begin
            errors++; $display("FAIL priority_mode%0d got v=%b st=%0d q=%h want 1 %0d %h",
                               mode, dif.out_valid, dif.out_status, dif.out_q, exp_st, exp_q);
        end
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        checks++;
        if (dif.jobs_done !== exp_jobs) begin errors++; $display("FAIL priority_jobs got %0d want %0d", dif.jobs_done, exp_jobs); end
        $display("priority mode %0d: status=%0d q=%h", mode, exp_st, exp_q);
    endtask

    task automatic test_abort(input int mode, input int exp_n, input logic [15:0] exp_jobs);
        int n;
        m_mode = mode; m_lat = 6; m_q = 10'h155;
        offer_job(10'd77, 10'd5);
        n = 0;
        while (!dif.div_abort && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != exp_n) begin errors++; $display("FAIL abort_mode%0d_delay got %0d want %0d", mode, n, exp_n); end
        tick();
        checks++;
        if (dif.div_abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got %b want 0", dif.div_abort); end
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_status !== 2'd3 || dif.out_q !== 10'h0) begin
            errors++; $display("FAIL abort_result got v=%b st=%0d q=%h want 1 3 000", dif.out_valid, dif.out_status, dif.out_q);
        end
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        checks++;
        if (dif.jobs_done !== exp_jobs) begin errors++; $display("FAIL abort_jobs got %0d want %0d", dif.jobs_done, exp_jobs); end
        $display("abort mode %0d: abort after %0d cycles, jobs_done=%0d", mode, n, dif.jobs_done);
    endtask

    task automatic test_back_to_back();
        int n;
        int bad_rdy;
        int bad_q;
        int bad_start;
        m_mode = M_VALID; m_lat = 3; m_q = 10'h02A;
        offer_job(10'd5, 10'd1);
        wait_out(n);
        dif.in_valid = 1'b1;
        dif.in_a     = 10'd9;
        dif.in_b     = 10'd2;
        bad_rdy = 0; bad_q = 0; bad_start = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dif.in_ready !== 1'b0) bad_rdy++;
            if (dif.out_q !== 10'h02A) bad_q++;
            if (dif.div_start !== 1'b0) bad_start++;
        end
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL bp_in_ready got %0d high cycles want 0", bad_rdy); end
        checks++;
        if (bad_q != 0) begin errors++; $display("FAIL bp_out_q_stable got %0d changed cycles want 0", bad_q); end
        checks++;
        if (bad_start != 0) begin errors++; $display("FAIL bp_no_start got %0d starts want 0", bad_start); end
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        checks++;
        if (dif.in_ready !== 1'b1 || dif.jobs_done !== 16'd6 || dif.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b jobs=%0d v=%b want 1 6 0", dif.in_ready, dif.jobs_done, dif.out_valid);
        end
        tick();
        dif.in_valid = 1'b0;
        checks++;
        if (dif.div_start !== 1'b1 || dif.div_a !== 10'd9 || dif.div_b !== 10'd2) begin
            errors++; $display("FAIL bp_second_accept got start=%b a=%0d b=%0d want 1 9 2", dif.div_start, dif.div_a, dif.div_b);
        end
        wait_out(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL bp_second_latency got %0d want 4", n); end
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        checks++;
        if (dif.jobs_done !== 16'd7) begin errors++; $display("FAIL bp_jobs got %0d want 7", dif.jobs_done); end
        $display("back_to_back: second job latency=%0d jobs_done=%0d", n, dif.jobs_done);
    endtask

    task automatic test_reset_mid_wait();
        m_mode = M_HANG;
        offer_job(10'd33, 10'd4);
        for (int i = 0; i < 5; i++) tick();
        m_en         = 1'b0;
        m_active     = 1'b0;
        dif.div_busy = 1'b0;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        checks++;
        if (dif.out_valid !== 1'b0 || dif.jobs_done !== 16'd0 || dif.in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_state got v=%b jobs=%0d rdy=%b want 0 0 1", dif.out_valid, dif.jobs_done, dif.in_ready);
        end
        checks++;
        if (dif.div_abort !== 1'b0) begin errors++; $display("FAIL midreset_no_abort got %b want 0", dif.div_abort); end
        dif.div_q     = 10'h111;
        dif.div_valid = 1'b1;
        tick();
        dif.div_valid = 1'b0;
        tick();
        checks++;
        if (dif.out_valid !== 1'b0 || dif.out_q !== 10'h0 || dif.in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_late_pulse got v=%b q=%h rdy=%b want 0 000 1", dif.out_valid, dif.out_q, dif.in_ready);
        end
        $display("reset_mid_wait: out_valid=%b in_ready=%b", dif.out_valid, dif.in_ready);
    endtask

    initial begin
        sclr          = 1'b1;
        dif.in_valid  = 1'b0;
        dif.in_a      = '0;
        dif.in_b      = '0;
        dif.out_ready = 1'b0;
        dif.div_busy  = 1'b0;
        dif.div_valid = 1'b0;
        dif.div_ovf   = 1'b0;
        dif.div_dvz   = 1'b0;
        dif.div_q     = '0;

        test_reset();
        test_normal();
        test_dvz();
        test_priority(M_OVF_VAL, 10'h155, 2'd1, 10'h155, 16'd3);
        test_priority(M_ALL,     10'h2AA, 2'd2, 10'h000, 16'd4);
        test_abort(M_HANG, TIMEOUT_CYC + 1, 16'd5);
        test_back_to_back();
        test_abort(M_SILENT, 4, 16'd8);
        test_reset_mid_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
